// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue.
//   FQ_WIDTH   : default width of an instruction word and of a PC
//   NOP_INSTR  : instruction decode substitutes while the queue is empty
//   fq_entry_t : one queued entry, instruction in the upper half, PC in the lower half
package fetch_pkg;

  localparam int FQ_WIDTH = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [FQ_WIDTH-1:0] instr;
    logic [FQ_WIDTH-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Entry storage for the fetch queue: DEPTH entries, one synchronous write
// port and one asynchronous read port (so the head can fall through).
//   clk   : clock, write on rising edge
//   we    : write enable
//   waddr : write slot
//   wdata : entry written, laid out as fq_entry_t ({instr, pc})
//   raddr : read slot
//   rdata : entry at raddr, combinational
// Contents are not reset; the parent masks anything that is not valid.
module fq_storage
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = $bits(fq_entry_t),
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between the fetch stage and decode.
// Holds {instr, pc} pairs in order and presents the oldest one to decode
// first-word-fall-through. A flush (taken branch) empties the queue.
//   clk, rst   : clock and synchronous active-high reset
//   flush      : discard every queued entry on this edge
//   in_valid / in_ready / in_instr / in_pc     : fetch side handshake + data
//   out_valid / out_ready / out_instr / out_pc : decode side handshake + data
//   count      : current occupancy, 0..DEPTH
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = FQ_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_instr,
  input  logic [WIDTH-1:0]       in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_instr,
  output logic [WIDTH-1:0]       out_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic                 push;
  logic                 pop;
  logic [2*WIDTH-1:0]   head_entry;

  // Both handshake flags come from registered count only, so neither side
  // sees a combinational path from the other. A full queue therefore
  // refuses a push even when decode is popping in the same cycle.
  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Any push or pop in this cycle is dropped along with the contents.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits so they wrap on their own.
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entries are stored with the fq_entry_t layout: instr high, pc low.
  fq_storage #(
    .DEPTH   (DEPTH),
    .ENTRY_W (2 * WIDTH)
  ) u_storage (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr_q),
    .wdata ({in_instr, in_pc}),
    .raddr (rd_ptr_q),
    .rdata (head_entry)
  );

  // Zero the data outputs when empty so stale slots never leak to decode.
  assign out_instr = out_valid ? head_entry[2*WIDTH-1:WIDTH] : '0;
  assign out_pc    = out_valid ? head_entry[WIDTH-1:0]       : '0;
  assign count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_instr = '0;
  logic [WIDTH-1:0] in_pc = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_pc;
  logic [CW-1:0]    count;

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Reference model: the queue contents as decode should see them.
  fq_entry_t exp_q[$];
  int        checks = 0;
  int        errors = 0;
  int        pre_size = 0;   // occupancy before this cycle's edge
  int        rdy_mode = 0;   // 0: never ready, 1: always ready, 2: random
  bit        chk_en = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor / consumer: compares DUT outputs to the model head at every
  // falling edge, then decides whether decode takes the head this cycle.
  initial begin
    bit        rdy;
    fq_entry_t head;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("count", 64'(count), 64'(exp_q.size()));
        check("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          check("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
          check("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
        end else begin
          check("out_instr_zero", 64'(out_instr), 64'd0);
          check("out_pc_zero", 64'(out_pc), 64'd0);
        end
      end
      pre_size = exp_q.size();
      case (rdy_mode)
        1:       rdy = 1'b1;
        2:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = 1'b0;
      endcase
      out_ready = rdy;
      if (rdy && exp_q.size() != 0) begin
        head = exp_q.pop_front();
        $display("pop  pc=%08h instr=%08h", head.pc, head.instr);
      end
    end
  end

  // Driver: applies one cycle of fetch-side stimulus and updates the model
  // with what the next rising edge must do.
  task automatic drive(input bit r, input bit f, input bit iv,
                       input logic [31:0] ins, input logic [31:0] pc);
    fq_entry_t e;
    @(negedge clk);
    #1;
    rst      = r;
    flush    = f;
    in_valid = iv;
    in_instr = ins;
    in_pc    = pc;
    if (r || f) begin
      exp_q.delete();
      if (r || f) $display("clear rst=%0d flush=%0d", r, f);
    end else if (iv && pre_size < DEPTH) begin
      e.instr = ins;
      e.pc    = pc;
      exp_q.push_back(e);
      $display("push pc=%08h instr=%08h", pc, ins);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    int p;
    // Reset for two cycles, then check idle state.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_en = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(2);

    // Single push with decode stalled, then drain it.
    rdy_mode = 0;
    drive(1'b0, 1'b0, 1'b1, 32'h00500093, 32'h0);
    idle(2);
    rdy_mode = 1;
    idle(2);

    // Fill to full, a fifth push must be dropped, then drain in order.
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 32'h1000 + 32'(i), 32'(4 * i));
    idle(1);
    rdy_mode = 1;
    idle(6);

    // Continuous streaming through pointer wrap.
    rdy_mode = 1;
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b1, 32'h2000 + 32'(i), 32'(4 * i));
    idle(3);

    // Flush with a simultaneous push, then a fresh push becomes the head.
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 32'h3000 + 32'(i), 32'(4 * i));
    drive(1'b0, 1'b1, 1'b1, 32'h3040, 32'h40);
    drive(1'b0, 1'b0, 1'b1, 32'h3080, 32'h80);
    idle(2);
    rdy_mode = 1;
    idle(2);

    // Reset wins over flush and push while holding two entries.
    rdy_mode = 0;
    drive(1'b0, 1'b0, 1'b1, 32'h4000, 32'h100);
    drive(1'b0, 1'b0, 1'b1, 32'h4004, 32'h104);
    drive(1'b1, 1'b1, 1'b1, 32'h4008, 32'h108);
    idle(2);

    // Randomized traffic with occasional flushes and resets.
    rdy_mode = 2;
    repeat (600) begin
      p = int'($urandom_range(0, 99));
      drive(p < 1, (p >= 1) && (p < 6), $urandom_range(0, 2) != 0, $urandom, $urandom);
    end
    rdy_mode = 1;
    idle(8);
    @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
